// File: rtl/bin2bcd.sv
// bin2bcd: registered double-dabble binary-to-BCD converter with overflow flag
module bin2bcd #(
    parameter int NUMBCDS = 4,
    parameter int NUMBIN  = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUMBIN-1:0]      bin,
    output logic [4*NUMBCDS-1:0]   bcd,
    output logic                   ovf
);
    localparam int NFULL = (NUMBIN * 30103) / 100000 + 1;
    localparam int ND    = NFULL > NUMBCDS ? NFULL : NUMBCDS;
    logic [4*ND-1:0] acc;
    logic            hi;
    // shift-add-3 over every input bit, MSB first, into a full-width digit array
    always_comb begin
        acc = '0;
        for (int i = NUMBIN - 1; i >= 0; i--) begin
            for (int k = 0; k < ND; k++)
                acc[4*k +: 4] = acc[4*k +: 4] >= 4'd5 ? acc[4*k +: 4] + 4'd3 : acc[4*k +: 4];
            acc = {acc[4*ND-2:0], bin[i]};
        end
    end
    if (ND > NUMBCDS) begin : g_ovf
        assign hi = |acc[4*ND-1:4*NUMBCDS];
    end else begin : g_no_ovf
        assign hi = 1'b0;
    end
    // outputs are pure registers: truncated low digits plus overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd <= '0;
            ovf <= 1'b0;
        end else begin
            bcd <= acc[4*NUMBCDS-1:0];
            ovf <= hi;
        end
    end
endmodule

// File: tb/tb_bin2bcd.sv
// tb_bin2bcd: scoreboard bench for bin2bcd at default and two alternate parameter sets
module tb_bin2bcd;
    typedef struct {
        int          v;
        logic [15:0] b;
        logic        o;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        ovf;
    logic [13:0] bin5;
    logic [19:0] bcd5;
    logic        ovf5;
    logic [7:0]  bin2;
    logic [7:0]  bcd2;
    logic        ovf2;
    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;

    bin2bcd dut (.clk(clk), .rst_n(rst_n), .bin(bin), .bcd(bcd), .ovf(ovf));
    bin2bcd #(.NUMBCDS(5), .NUMBIN(14)) dut5 (.clk(clk), .rst_n(rst_n), .bin(bin5), .bcd(bcd5), .ovf(ovf5));
    bin2bcd #(.NUMBCDS(2), .NUMBIN(8)) dut2 (.clk(clk), .rst_n(rst_n), .bin(bin2), .bcd(bcd2), .ovf(ovf2));

    always #5 clk = ~clk;

    function automatic exp_t model(input int v);
        exp_t e;
        int   x;
        e.v = v;
        e.b = '0;
        x = v;
        for (int k = 0; k < 4; k++) begin
            e.b[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        e.o = v > 9999;
        return e;
    endfunction

    task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
            $error("%s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int v);
        exp_t e;
        bin = 14'(v);
        q.push_back(model(v));
        @(negedge clk);
        if (q.size() == 0) begin
            check("scoreboard_empty", 20'd1, 20'd0);
        end else begin
            e = q.pop_front();
            check($sformatf("bcd(%0d)", e.v), {4'h0, bcd}, {4'h0, e.b});
            check($sformatf("ovf(%0d)", e.v), {19'h0, ovf}, {19'h0, e.o});
        end
    endtask

    function automatic logic bad_nibble(input logic [15:0] b);
        logic r = 1'b0;
        for (int k = 0; k < 4; k++) r |= b[4*k +: 4] > 4'd9;
        return r;
    endfunction

    initial begin
        rst_n = 1'b0;
        bin   = 14'd1234;
        bin5  = '0;
        bin2  = '0;
        repeat (3) @(negedge clk);
        check("reset_bcd", {4'h0, bcd}, 20'h0);
        check("reset_ovf", {19'h0, ovf}, 20'h0);
        check("reset_bcd5", bcd5, 20'h0);
        rst_n = 1'b1;
        tick(1234);
        tick(0);
        tick(10);
        tick(255);
        tick(9999);
        tick(16383);
        tick(10000);
        tick(0);
        tick(1);
        tick(9);
        tick(99);
        tick(999);
        tick(9999);
        @(posedge clk);
        #1 bin = 14'd42;
        #1 check("hold_after_edge", {4'h0, bcd}, 20'h09999);
        @(negedge clk);
        check("hold_mid_cycle", {4'h0, bcd}, 20'h09999);
        @(posedge clk);
        #1 check("latency_new", {4'h0, bcd}, 20'h00042);
        #1 rst_n = 1'b0;
        #1 check("async_clear_bcd", {4'h0, bcd}, 20'h0);
        check("async_clear_ovf", {19'h0, ovf}, 20'h0);
        @(negedge clk);
        check("reset_hold", {4'h0, bcd}, 20'h0);
        rst_n = 1'b1;
        for (int v = 0; v < 16384; v++) begin
            tick(v);
            check($sformatf("nibble(%0d)", v), {19'h0, bad_nibble(bcd)}, 20'h0);
        end
        bin5 = 14'd16383;
        bin2 = 8'd255;
        @(negedge clk);
        check("p5_bcd_16383", bcd5, 20'h16383);
        check("p5_ovf_16383", {19'h0, ovf5}, 20'h0);
        check("p2_bcd_255", {12'h0, bcd2}, 20'h00055);
        check("p2_ovf_255", {19'h0, ovf2}, 20'h1);
        bin5 = 14'd9999;
        bin2 = 8'd99;
        @(negedge clk);
        check("p5_bcd_9999", bcd5, 20'h09999);
        check("p2_bcd_99", {12'h0, bcd2}, 20'h00099);
        check("p2_ovf_99", {19'h0, ovf2}, 20'h0);
        bin2 = 8'd100;
        @(negedge clk);
        check("p2_bcd_100", {12'h0, bcd2}, 20'h00000);
        check("p2_ovf_100", {19'h0, ovf2}, 20'h1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
